reel_ctrl: RTL
==============

# reel_ctrl

Slot-machine reel sequencer sitting directly downstream of the push-button debouncer. It consumes the debounced button level, synchronises it into the `clk` domain and turns each press into a single-cycle event. It then walks a three-reel spin/stop sequence, producing reel symbol values, per-reel spinning flags and a registered win/jackpot result for the display and payout logic.

## Interface
- `NUM_SYMBOLS`, 8: symbols per reel; values 0..NUM_SYMBOLS-1.
- `SYM_W`, 3: symbol width, ≥ clog2(NUM_SYMBOLS).
- `STEP_DIV`, 5_000_000: `clk` cycles per reel step.
- `MIN_STEPS`, 3: steps required in each spin state before a stop press is accepted.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_db`  in  1  debounced button level from the debouncer, asynchronous to `clk`.
- `reel0`, `reel1`, `reel2`  out  SYM_W each  current symbol per reel.
- `spinning`  out  3  bit k high while reel k advances.
- `busy`  out  1  high in SPIN3/SPIN2/SPIN1/EVAL.
- `done`  out  1  one-cycle pulse when a result becomes valid.
- `win`  out  1  at least two stopped reels equal.
- `jackpot`  out  1  all three reels equal.

## Operation
- **Press path:**
  - `btn_db` passes through a 2-flop synchronizer, then a previous-value register.
  - `press` = sync & ~prev. There is exactly one press per rising level; holding the button produces no repeats.
- **Step tick:**
  - Free-running 32-bit divider counts 0..STEP_DIV-1.
  - `tick` is asserted for one cycle when the count equals STEP_DIV-1, then the count wraps to 0.
- **Reel advance:** on `tick`, every reel with its spinning bit set goes to (v+1) mod NUM_SYMBOLS. NUM_SYMBOLS-1 wraps to 0.
- **Guard counter:**
  - Cleared on entry to any SPIN state; increments on `tick`; saturates at MIN_STEPS.
  - In a SPIN state, `press` is honoured only when the guard count ≥ MIN_STEPS. Otherwise it is dropped.
- **States:**
  - IDLE --press--> SPIN3: spinning=111; win and jackpot cleared.
  - SPIN3 --press--> SPIN2: reel0 stops; spinning=110.
  - SPIN2 --press--> SPIN1: reel1 stops; spinning=100.
  - SPIN1 --press--> EVAL: reel2 stops; spinning=000.
  - EVAL --> SHOW, unconditionally after 1 cycle:
    - jackpot = (r0==r1 && r1==r2).
    - win = jackpot | (r0==r1) | (r1==r2) | (r0==r2).
    - `done` pulses.
  - SHOW --press--> SPIN3: win and jackpot cleared. No guard applies in SHOW or IDLE.
- **Simultaneous press and tick:** the stop wins. The reel being stopped keeps its pre-tick value, while reels still spinning advance.
- **Reset values:**
  - State IDLE; reels 0,0,0; spinning 000; busy, done, win, jackpot 0.
  - Divider, guard counter and sync flops 0.
- **Reset mid-operation:** asynchronous return to the reset values. After release, a fresh rising `btn_db` edge is required to start. A button already held high at release produces a press once sync/prev settle.

## Timing
- `btn_db` first sampled high at edge N:
  - Sync output is high after edge N+1.
  - The state and `spinning` update at edge N+2.
  - Latency is 3 edges including the sampling edge.
- Reel values change only on the edge where `tick` is high.
- `done`, `win` and `jackpot` update on the EVAL→SHOW edge, exactly 1 cycle after the edge that left SPIN1.
- `done` is high for exactly one cycle. `win` and `jackpot` hold through SHOW.
- All outputs are registered. No combinational path from `btn_db` to any output.

## Structure
- Shared package `slot_pkg`:
  - State enum (IDLE, SPIN3, SPIN2, SPIN1, EVAL, SHOW).
  - `SYM_W` and symbol typedef.
  - Reel-count constant 3.
- Sub-module `btn_edge`: 2-flop synchronizer plus rising-edge pulse. Reusable for other debounced buttons.
- Top level holds the divider, guard counter, FSM, reel registers and evaluator.

## Test plan
All scenarios use STEP_DIV=4, MIN_STEPS=2, NUM_SYMBOLS=8.
- **Reset:** `rst_n` low with `clk` stopped → all outputs 0 immediately. Release → state IDLE, reels 0,0,0.
- **Start and wrap:**
  - `btn_db` rises at edge N → `spinning`=111 and `busy`=1 after edge N+2.
  - Reels increment every 4 cycles; value 7 wraps to 0.
- **Guard:**
  - Press 1 tick after entering SPIN3 → ignored, `spinning` stays 111.
  - Press after the 2nd tick → `spinning`=110 and reel0 frozen.
- **Jackpot:**
  - Stop all three reels when each shows 5 → one-cycle `done`, `win`=1, `jackpot`=1, held in SHOW.
  - Next press clears both flags and sets `spinning`=111.
- **Pair, then collision:**
  - Reels stop at 2,2,6 → `win`=1, `jackpot`=0.
  - Align a stop press with `tick` while reel0 shows 4 → reel0 stays 4 and reel1 advances.
- **Mid-spin reset:** assert `rst_n` in SPIN2 → reels 0, `spinning` 000, `busy` 0 at once. Holding `btn_db` low → stays IDLE.

Source files
------------

// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared types and constants for the reel sequencer
package slot_pkg;

    localparam int SYM_W     = 3;
    localparam int NUM_REELS = 3;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPIN3,
        ST_SPIN2,
        ST_SPIN1,
        ST_EVAL,
        ST_SHOW
    } state_e;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchronizer with single-cycle rising-edge pulse
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign press_o = s2_q & ~prev_q;

endmodule

// File: rtl/reel_ctrl.sv
// rtl/reel_ctrl.sv - three-reel spin/stop sequencer with registered win/jackpot result
module reel_ctrl #(
    parameter int NUM_SYMBOLS = 8,
    parameter int SYM_W       = 3,
    parameter int STEP_DIV    = 5_000_000,
    parameter int MIN_STEPS   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_db,
    output logic [SYM_W-1:0] reel0,
    output logic [SYM_W-1:0] reel1,
    output logic [SYM_W-1:0] reel2,
    output logic [2:0]       spinning,
    output logic             busy,
    output logic             done,
    output logic             win,
    output logic             jackpot
);
    import slot_pkg::*;

    logic press;

    btn_edge u_btn_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_db),
        .press_o(press)
    );

    logic [31:0] div_q, div_d;
    logic        tick;
    logic [31:0] guard_q, guard_d;
    logic        guard_ok;
    state_e      state_q, state_d;
    logic [NUM_REELS-1:0][SYM_W-1:0] reel_q, reel_d;
    logic [NUM_REELS-1:0] spin_q, spin_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        win_q, win_d;
    logic        jack_q, jack_d;
    logic        eq01, eq12, eq02;

    assign tick     = (div_q == 32'(STEP_DIV - 1));
    assign div_d    = tick ? '0 : div_q + 32'd1;
    assign guard_ok = (guard_q >= 32'(MIN_STEPS));
    assign eq01     = (reel_q[0] == reel_q[1]);
    assign eq12     = (reel_q[1] == reel_q[2]);
    assign eq02     = (reel_q[0] == reel_q[2]);

    always_comb begin
        state_d = state_q;
        spin_d  = spin_q;
        win_d   = win_q;
        jack_d  = jack_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_SHOW: if (press) begin
                state_d = ST_SPIN3;
                spin_d  = 3'b111;
                win_d   = 1'b0;
                jack_d  = 1'b0;
            end
            ST_SPIN3: if (press && guard_ok) begin
                state_d = ST_SPIN2;
                spin_d  = 3'b110;
            end
            ST_SPIN2: if (press && guard_ok) begin
                state_d = ST_SPIN1;
                spin_d  = 3'b100;
            end
            ST_SPIN1: if (press && guard_ok) begin
                state_d = ST_EVAL;
                spin_d  = 3'b000;
            end
            ST_EVAL: begin
                state_d = ST_SHOW;
                done_d  = 1'b1;
                jack_d  = eq01 & eq12;
                win_d   = eq01 | eq12 | eq02;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any state change clears the guard; only entries into SPIN states rely on it.
        if (state_d != state_q)
            guard_d = '0;
        else if (tick && !guard_ok)
            guard_d = guard_q + 32'd1;
        else
            guard_d = guard_q;

        busy_d = (state_d == ST_SPIN3) || (state_d == ST_SPIN2) ||
                 (state_d == ST_SPIN1) || (state_d == ST_EVAL);

        // A reel stopped on a tick edge keeps its pre-tick symbol.
        reel_d = reel_q;
        for (int k = 0; k < NUM_REELS; k++) begin
            if (tick && spin_q[k] && spin_d[k])
                reel_d[k] = (reel_q[k] == SYM_W'(NUM_SYMBOLS - 1)) ? '0 : reel_q[k] + SYM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            guard_q <= '0;
            reel_q  <= '0;
            spin_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
            jack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            guard_q <= guard_d;
            reel_q  <= reel_d;
            spin_q  <= spin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            win_q   <= win_d;
            jack_q  <= jack_d;
        end
    end

    assign reel0    = reel_q[0];
    assign reel1    = reel_q[1];
    assign reel2    = reel_q[2];
    assign spinning = spin_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign win      = win_q;
    assign jackpot  = jack_q;

endmodule
